sseg_word_display: RTL and testbench

- Downstream consumer of the writeback data buffer.
- Pops 32-bit writeback words through a show-ahead valid/ready handshake.
- Holds each word on the 8-digit seven-segment display for a minimum dwell time, shown as 8 hex digits through time-multiplexed anode scanning.
- Provides the display path in place of a free-running GPIO display, so that every retired writeback is visible for at least one dwell period.

---
 rtl/sseg_word_display_if.sv | 17 +
 rtl/sseg_word_display.sv | 145 ++++++++++++++
 tb/tb_sseg_word_display.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/sseg_word_display_if.sv
// -----------------------------------------------------------------------------
// sseg_word_display_if
// Show-ahead pop handshake between the writeback data buffer and the
// seven-segment word display.
//   word_in    : head-of-buffer word, valid together with word_valid
//   word_valid : buffer non-empty
//   word_ready : one-cycle pop strobe from the consumer
// Modports: master = buffer side, slave = display side.
// -----------------------------------------------------------------------------
interface sseg_word_display_if;
    logic [31:0] word_in;
    logic        word_valid;
    logic        word_ready;

    modport master (output word_in, output word_valid, input word_ready);
    modport slave  (input word_in, input word_valid, output word_ready);
endinterface

// File: rtl/sseg_word_display.sv
// -----------------------------------------------------------------------------
// sseg_word_display
// Pops 32-bit writeback words from the buffer and holds each one on the
// 8-digit seven-segment display for at least DWELL_CYCLES clocks, scanning the
// anodes so every digit is lit for SCAN_DIV clocks in turn.
//
// Ports:
//   clk      : system clock
//   rst      : synchronous, active-high reset
//   wb       : pop handshake (slave side: word_in, word_valid in; word_ready out)
//   SSEG_AN  : anode enables, active-low, one-hot, bit 0 = rightmost digit
//   SSEG_CA  : cathodes, active-low, [6:0]=gfedcba, [7]=dp (always off)
//   busy     : dwell counter nonzero
//
// Optional build macro: SSEG_LEADING_ZERO_BLANK_EN
//   When defined, digits above the most significant nonzero nibble stay unlit.
//
// FSM states:
//   state | meaning
//   IDLE  | nothing popped since reset, display blank
//   SHOW  | displaying the last popped word
// -----------------------------------------------------------------------------
module sseg_word_display #(
    parameter int SCAN_DIV     = 100000,
    parameter int DWELL_CYCLES = 100000000
) (
    input  logic                 clk,
    input  logic                 rst,
    sseg_word_display_if.slave   wb,
    output logic [7:0]           SSEG_AN,
    output logic [7:0]           SSEG_CA,
    output logic                 busy
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DWELL_CYCLES);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYCLES - 1);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t         state_q, state_d;
    logic [31:0]    word_q, word_d;
    logic [2:0]     idx_q, idx_d;
    logic [SW-1:0]  scan_q, scan_d;
    logic [DW-1:0]  dwell_q, dwell_d;
    logic [7:0]     an_q, an_d;
    logic [7:0]     ca_q, ca_d;
    logic           pop;
    logic [3:0]     nibble;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    // Index of the most significant nonzero nibble; 0 for an all-zero word so
    // digit 0 always stays lit.
    logic [2:0] msn;
    always_comb begin
        msn = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (word_q[4*i +: 4] != 4'h0) msn = 3'(i);
        end
    end
`endif

    // rst is folded in so a word offered during reset is never popped.
    assign pop           = (state_q == IDLE || dwell_q == '0) && wb.word_valid && !rst;
    assign wb.word_ready = pop;
    assign busy          = (dwell_q != '0);
    assign SSEG_AN       = an_q;
    assign SSEG_CA       = ca_q;
    assign nibble        = word_q[{idx_q, 2'b00} +: 4];

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        scan_d  = scan_q + 1'b1;
        dwell_d = dwell_q;
        an_d    = 8'hFF;
        ca_d    = 8'hFF;

        // Scan runs in both states and is not disturbed by pops.
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            idx_d  = idx_q + 3'd1;
        end

        if (pop) begin
            word_d  = wb.word_in;
            dwell_d = DWELL_LOAD;
            state_d = SHOW;
        end else if (dwell_q != '0) begin
            dwell_d = dwell_q - 1'b1;
        end

        if (state_q == SHOW) begin
            an_d = ~(8'b1 << idx_q);
            ca_d = {1'b1, seg7(nibble)};
`ifdef SSEG_LEADING_ZERO_BLANK_EN
            if (idx_q > msn) an_d = 8'hFF;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            scan_q  <= '0;
            dwell_q <= '0;
            an_q    <= 8'hFF;
            ca_q    <= 8'hFF;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            scan_q  <= scan_d;
            dwell_q <= dwell_d;
            an_q    <= an_d;
            ca_q    <= ca_d;
        end
    end

endmodule

// File: tb/tb_sseg_word_display.sv
// -----------------------------------------------------------------------------
// tb_sseg_word_display
// Self-checking bench for sseg_word_display with SCAN_DIV=4, DWELL_CYCLES=20.
// The reference model tracks cycles since reset and the time of the last pop,
// and derives digit index, dwell state and expected display from those.
// -----------------------------------------------------------------------------
module tb_sseg_word_display;
    localparam int S = 4;
    localparam int D = 20;

    localparam logic [7:0] SEG_TBL [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    // CA values for 32'h1234_ABCD, indexed by digit (0 = rightmost).
    localparam logic [7:0] EXP_1234 [8] = '{
        8'hA1, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] an, ca;
    logic       busy;
    int         checks = 0;
    int         errors = 0;

    sseg_word_display_if wb();

    sseg_word_display #(.SCAN_DIV(S), .DWELL_CYCLES(D)) dut (
        .clk     (clk),
        .rst     (rst),
        .wb      (wb.slave),
        .SSEG_AN (an),
        .SSEG_CA (ca),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          m_c     = 0;   // cycles since the last reset edge
    int          m_pop_c = 0;   // cycle in which the last pop happened
    int          m_idx   = 0;
    bit          m_shown = 1'b0;
    logic [31:0] m_word  = '0;
    logic [7:0]  m_an    = 8'hFF;
    logic [7:0]  m_ca    = 8'hFF;

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    function automatic int top_nibble(input logic [31:0] w);
        for (int i = 7; i > 0; i--) if (((w >> (4*i)) & 32'hF) != 0) return i;
        return 0;
    endfunction
`endif

    function automatic bit exp_ready();
        return !rst && wb.word_valid && (!m_shown || (m_c - m_pop_c) >= D);
    endfunction

    function automatic bit exp_busy();
        return m_shown && (m_c - m_pop_c) < D;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_c = 0; m_pop_c = 0; m_shown = 1'b0; m_word = '0;
            m_an = 8'hFF; m_ca = 8'hFF;
        end else begin
            m_idx = (m_c / S) % 8;
            if (m_shown) begin
                m_an = ~(8'h01 << m_idx);
                m_ca = SEG_TBL[m_word[4*m_idx +: 4]];
`ifdef SSEG_LEADING_ZERO_BLANK_EN
                if (m_idx > top_nibble(m_word)) m_an = 8'hFF;
`endif
            end else begin
                m_an = 8'hFF; m_ca = 8'hFF;
            end
            if (exp_ready()) begin
                m_word  = wb.word_in;
                m_shown = 1'b1;
                m_pop_c = m_c;
            end
            m_c++;
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; wb.word_valid = 1'b0; wb.word_in = $urandom;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (an !== 8'hFF) begin errors++; $display("FAIL reset_an got %h exp ff", an); end
        checks++; if (ca !== 8'hFF) begin errors++; $display("FAIL reset_ca got %h exp ff", ca); end
        checks++; if (wb.word_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", wb.word_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); rst = 1'b0; wb.word_in = $urandom; #1;
            checks++; if (an !== 8'hFF || ca !== 8'hFF) begin errors++; $display("FAIL idle_blank got %h/%h exp ff/ff", an, ca); end
            checks++; if (wb.word_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_ctrl got ready=%b busy=%b exp 0/0", wb.word_ready, busy); end
        end
    endtask

    task automatic test_single_word();
        int nb = 0;
        @(negedge clk); wb.word_in = 32'h1234_ABCD; wb.word_valid = 1'b1; #1;
        checks++; if (wb.word_ready !== 1'b1) begin errors++; $display("FAIL first_pop got %b exp 1", wb.word_ready); end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); wb.word_valid = 1'b0; wb.word_in = $urandom; #1;
            if (busy === 1'b1) nb++;
            checks++; if (an !== m_an || ca !== m_ca) begin errors++; $display("FAIL single_disp got %h/%h exp %h/%h", an, ca, m_an, m_ca); end
            checks++; if (busy !== exp_busy()) begin errors++; $display("FAIL single_busy got %b exp %b", busy, exp_busy()); end
            for (int k = 0; k < 8; k++) begin
                if (an === ~(8'h01 << k)) begin
                    checks++; if (ca !== EXP_1234[k]) begin errors++; $display("FAIL digit%0d_ca got %h exp %h", k, ca, EXP_1234[k]); end
                end
            end
        end
        checks++; if (nb != D - 1) begin errors++; $display("FAIL busy_len got %0d exp %0d", nb, D - 1); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q[$];
        int pops[$];
        for (int i = 0; i < 3; i++) q.push_back($urandom);
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (q.size() > 0) begin wb.word_valid = 1'b1; wb.word_in = q[0]; end
            else begin wb.word_valid = 1'b0; wb.word_in = $urandom; end
            #1;
            checks++; if (wb.word_ready !== exp_ready()) begin errors++; $display("FAIL b2b_ready got %b exp %b", wb.word_ready, exp_ready()); end
            checks++; if (an !== m_an || ca !== m_ca) begin errors++; $display("FAIL b2b_disp got %h/%h exp %h/%h", an, ca, m_an, m_ca); end
            if (exp_ready()) begin pops.push_back(c); void'(q.pop_front()); end
        end
        checks++;
        if (pops.size() != 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", pops.size()); end
        else if (pops[1] - pops[0] != D || pops[2] - pops[1] != D) begin
            errors++; $display("FAIL b2b_interval got %0d,%0d exp %0d", pops[1] - pops[0], pops[2] - pops[1], D);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 230; i++) begin
            @(negedge clk); wb.word_valid = 1'b0; wb.word_in = $urandom; #1;
            checks++; if (wb.word_ready !== 1'b0) begin errors++; $display("FAIL hold_ready got %b exp 0", wb.word_ready); end
            checks++; if (an !== m_an || ca !== m_ca || busy !== exp_busy()) begin
                errors++; $display("FAIL hold_disp got %h/%h/%b exp %h/%h/%b", an, ca, busy, m_an, m_ca, exp_busy()); end
        end
        @(negedge clk); wb.word_valid = 1'b1; wb.word_in = $urandom; #1;
        checks++; if (wb.word_ready !== 1'b1) begin errors++; $display("FAIL hold_repop got %b exp 1", wb.word_ready); end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); wb.word_valid = 1'b0; #1;
            checks++; if (an !== m_an || ca !== m_ca) begin errors++; $display("FAIL hold_new got %h/%h exp %h/%h", an, ca, m_an, m_ca); end
        end
    endtask

    task automatic test_reset_mid_dwell();
        @(negedge clk); wb.word_valid = 1'b1; wb.word_in = $urandom; #1;
        checks++; if (wb.word_ready !== 1'b1) begin errors++; $display("FAIL mid_pop got %b exp 1", wb.word_ready); end
        repeat (5) begin @(negedge clk); wb.word_valid = 1'b0; end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); rst = 1'b1; wb.word_valid = 1'b1; wb.word_in = $urandom; #1;
            checks++; if (wb.word_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b exp 0", wb.word_ready); end
            if (i > 0) begin
                checks++; if (an !== 8'hFF || ca !== 8'hFF || busy !== 1'b0) begin
                    errors++; $display("FAIL mid_rst_out got %h/%h/%b exp ff/ff/0", an, ca, busy); end
            end
        end
        @(negedge clk); rst = 1'b0; wb.word_valid = 1'b1; wb.word_in = $urandom; #1;
        checks++; if (wb.word_ready !== 1'b1) begin errors++; $display("FAIL post_rst_pop got %b exp 1", wb.word_ready); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); wb.word_valid = 1'b0; #1;
            checks++; if (an !== m_an || ca !== m_ca || busy !== exp_busy()) begin
                errors++; $display("FAIL post_rst_disp got %h/%h/%b exp %h/%h/%b", an, ca, busy, m_an, m_ca, exp_busy()); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            wb.word_valid = ($urandom_range(0, 3) == 0);
            wb.word_in = $urandom;
            #1;
            checks++; if (wb.word_ready !== exp_ready()) begin errors++; $display("FAIL rnd_ready got %b exp %b", wb.word_ready, exp_ready()); end
            checks++; if (busy !== exp_busy()) begin errors++; $display("FAIL rnd_busy got %b exp %b", busy, exp_busy()); end
            checks++; if (an !== m_an || ca !== m_ca) begin errors++; $display("FAIL rnd_disp got %h/%h exp %h/%h", an, ca, m_an, m_ca); end
        end
        @(negedge clk); rst = 1'b0; wb.word_valid = 1'b0;
    endtask

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    task automatic test_blank();
        logic [31:0] words [2] = '{32'h0000_00A5, 32'h0};
        for (int w = 0; w < 2; w++) begin
            repeat (D) begin @(negedge clk); wb.word_valid = 1'b0; end
            @(negedge clk); wb.word_valid = 1'b1; wb.word_in = words[w];
            for (int i = 0; i < 80; i++) begin
                @(negedge clk); wb.word_valid = 1'b0; #1;
                if (i > 1) begin
                    checks++;
                    if (w == 0 && !(an === 8'hFF || (an === 8'hFE && ca === 8'h92) || (an === 8'hFD && ca === 8'h88))) begin
                        errors++; $display("FAIL blank_a5 got %h/%h", an, ca); end
                    else if (w == 1 && !(an === 8'hFF || (an === 8'hFE && ca === 8'hC0))) begin
                        errors++; $display("FAIL blank_zero got %h/%h", an, ca); end
                end
            end
        end
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        wb.word_valid = 1'b0;
        wb.word_in = '0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_hold();
        test_reset_mid_dwell();
        test_random();
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        test_blank();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
